// File: rtl/bus_master_serializer.sv
// Master-side serial bus front end: arbitrates for the bus, shifts out a transaction address
// LSB first, then shifts out write data or collects serial read data with an idle timeout.
module bus_master_serializer #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  bus_req,
  input  logic                  bus_grant,
  output logic                  bus_data_out,
  output logic                  bus_data_out_valid,
  output logic                  bus_mode,
  output logic                  bus_rw,
  input  logic                  rdata_in,
  input  logic                  rdata_in_valid
);

  localparam int unsigned MaxW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CntW  = $clog2(MaxW);
  localparam int unsigned AIdxW = $clog2(ADDR_WIDTH);
  localparam int unsigned DIdxW = $clog2(DATA_WIDTH);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAddr,
    StWdata,
    StRdata,
    StDone
  } state_e;

  state_e                state;
  logic                  rw_l;
  logic [ADDR_WIDTH-1:0] addr_l;
  logic [DATA_WIDTH-1:0] wdata_l;
  logic [DATA_WIDTH-1:0] rdata_sh;
  logic [CntW-1:0]       cnt;
  logic [TmoW-1:0]       tmo;

  logic [CntW-1:0]       cnt_inc;
  logic                  addr_last;
  logic                  data_last;
  logic [TmoW-1:0]       tmo_inc;
  logic                  tmo_hit;
  logic [DATA_WIDTH-1:0] rdata_fill;

  assign cnt_inc   = cnt + CntW'(1);
  assign addr_last = (cnt == CntW'(ADDR_WIDTH - 1));
  assign data_last = (cnt == CntW'(DATA_WIDTH - 1));
  // Saturating idle counter; reaching the limit aborts the read.
  assign tmo_inc   = (tmo == TmoW'(TIMEOUT_CYCLES)) ? tmo : tmo + TmoW'(1);
  assign tmo_hit   = (tmo_inc == TmoW'(TIMEOUT_CYCLES));

  // Shift register with the bit arriving this cycle merged in, so rdata is valid with done.
  always_comb begin
    rdata_fill = rdata_sh;
    rdata_fill[cnt[DIdxW-1:0]] = rdata_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= StIdle;
      rw_l               <= 1'b0;
      addr_l             <= '0;
      wdata_l            <= '0;
      rdata_sh           <= '0;
      cnt                <= '0;
      tmo                <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
      rdata              <= '0;
      bus_req            <= 1'b0;
      bus_data_out       <= 1'b0;
      bus_data_out_valid <= 1'b0;
      bus_mode           <= 1'b0;
      bus_rw             <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            rw_l     <= rw;
            addr_l   <= addr;
            wdata_l  <= wdata;
            rdata_sh <= '0;
            busy     <= 1'b1;
            bus_req  <= 1'b1;
            bus_rw   <= rw;
            state    <= StReq;
          end
        end

        StReq: begin
          if (bus_grant) begin
            state              <= StAddr;
            cnt                <= '0;
            bus_data_out       <= addr_l[0];
            bus_data_out_valid <= 1'b1;
            bus_mode           <= 1'b0;
          end
        end

        StAddr: begin
          if (addr_last) begin
            cnt      <= '0;
            bus_mode <= 1'b1;
            if (rw_l) begin
              state        <= StWdata;
              bus_data_out <= wdata_l[0];
            end else begin
              state              <= StRdata;
              tmo                <= '0;
              bus_data_out       <= 1'b0;
              bus_data_out_valid <= 1'b0;
            end
          end else begin
            cnt          <= cnt_inc;
            bus_data_out <= addr_l[cnt_inc[AIdxW-1:0]];
          end
        end

        StWdata: begin
          if (data_last) begin
            state              <= StDone;
            done               <= 1'b1;
            bus_req            <= 1'b0;
            bus_data_out       <= 1'b0;
            bus_data_out_valid <= 1'b0;
            bus_mode           <= 1'b0;
          end else begin
            cnt          <= cnt_inc;
            bus_data_out <= wdata_l[cnt_inc[DIdxW-1:0]];
          end
        end

        StRdata: begin
          // A valid bit always takes priority over the timeout.
          if (rdata_in_valid) begin
            rdata_sh <= rdata_fill;
            cnt      <= cnt_inc;
            tmo      <= '0;
            if (data_last) begin
              state    <= StDone;
              done     <= 1'b1;
              rdata    <= rdata_fill;
              bus_req  <= 1'b0;
              bus_mode <= 1'b0;
            end
          end else begin
            tmo <= tmo_inc;
            if (tmo_hit) begin
              state    <= StDone;
              done     <= 1'b1;
              err      <= 1'b1;
              rdata    <= '0;
              bus_req  <= 1'b0;
              bus_mode <= 1'b0;
            end
          end
        end

        StDone: begin
          state  <= StIdle;
          busy   <= 1'b0;
          bus_rw <= 1'b0;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule
